// File: rtl/bsg_nasti_slave_if.sv
// NASTI responder-side bus bundle: AW/W/AR requests, R/B responses, and the
// request/response packet ports toward the channel tunnel.
interface bsg_nasti_slave_if #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 64,
  parameter int id_width_p   = 5
);
  localparam int pkt_width_p = 4 + id_width_p + data_width_p;

  logic                    nasti_aw_valid_i;
  logic [addr_width_p-1:0] nasti_aw_addr_i;
  logic [7:0]              nasti_aw_len_i;
  logic [id_width_p-1:0]   nasti_aw_id_i;
  logic                    nasti_aw_ready_o;

  logic                    nasti_w_valid_i;
  logic [data_width_p-1:0] nasti_w_data_i;
  logic                    nasti_w_last_i;
  logic                    nasti_w_ready_o;

  logic                    nasti_ar_valid_i;
  logic [addr_width_p-1:0] nasti_ar_addr_i;
  logic [7:0]              nasti_ar_len_i;
  logic [id_width_p-1:0]   nasti_ar_id_i;
  logic                    nasti_ar_ready_o;

  logic                    nasti_r_valid_o;
  logic [data_width_p-1:0] nasti_r_data_o;
  logic                    nasti_r_last_o;
  logic [id_width_p-1:0]   nasti_r_id_o;
  logic [1:0]              nasti_r_resp_o;
  logic                    nasti_r_ready_i;

  logic                    nasti_b_valid_o;
  logic [id_width_p-1:0]   nasti_b_id_o;
  logic [1:0]              nasti_b_resp_o;
  logic                    nasti_b_ready_i;

  logic                    req_v_o;
  logic [pkt_width_p-1:0]  req_data_o;
  logic                    req_yumi_i;

  logic                    resp_v_i;
  logic [pkt_width_p-1:0]  resp_data_i;
  logic                    resp_yumi_o;

  modport slave (
    input  nasti_aw_valid_i, nasti_aw_addr_i, nasti_aw_len_i, nasti_aw_id_i,
    output nasti_aw_ready_o,
    input  nasti_w_valid_i, nasti_w_data_i, nasti_w_last_i,
    output nasti_w_ready_o,
    input  nasti_ar_valid_i, nasti_ar_addr_i, nasti_ar_len_i, nasti_ar_id_i,
    output nasti_ar_ready_o,
    output nasti_r_valid_o, nasti_r_data_o, nasti_r_last_o, nasti_r_id_o, nasti_r_resp_o,
    input  nasti_r_ready_i,
    output nasti_b_valid_o, nasti_b_id_o, nasti_b_resp_o,
    input  nasti_b_ready_i,
    output req_v_o, req_data_o,
    input  req_yumi_i,
    input  resp_v_i, resp_data_i,
    output resp_yumi_o
  );

  modport master (
    output nasti_aw_valid_i, nasti_aw_addr_i, nasti_aw_len_i, nasti_aw_id_i,
    input  nasti_aw_ready_o,
    output nasti_w_valid_i, nasti_w_data_i, nasti_w_last_i,
    input  nasti_w_ready_o,
    output nasti_ar_valid_i, nasti_ar_addr_i, nasti_ar_len_i, nasti_ar_id_i,
    input  nasti_ar_ready_o,
    input  nasti_r_valid_o, nasti_r_data_o, nasti_r_last_o, nasti_r_id_o, nasti_r_resp_o,
    output nasti_r_ready_i,
    input  nasti_b_valid_o, nasti_b_id_o, nasti_b_resp_o,
    output nasti_b_ready_i,
    input  req_v_o, req_data_o,
    output req_yumi_i,
    output resp_v_i, resp_data_i,
    input  resp_yumi_o
  );
endinterface

// File: rtl/bsg_nasti_slave.sv
// Responder end of the FSB-tunnelled NASTI link: serializes AR/AW/W into request
// packets and unpacks R/B response packets. Optional macro: BSG_NASTI_SLAVE_RESP_CHECK_EN.
module bsg_nasti_slave #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 64,
  parameter int id_width_p   = 5,
  parameter int max_out_p    = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  bsg_nasti_slave_if.slave bus,
  output logic             error_o
);
  localparam int pkt_width_p  = 4 + id_width_p + data_width_p;
  localparam int cnt_width_lp = $clog2(max_out_p) + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, WDATA = 1'b1} state_e;

  function automatic logic [cnt_width_lp-1:0] f_cnt_next(
    input logic [cnt_width_lp-1:0] cnt, input logic inc, input logic dec);
    logic [cnt_width_lp-1:0] res;
    res = cnt;
    if (inc && !dec) res = cnt + cnt_width_lp'(1);
    else if (dec && !inc && (cnt != '0)) res = cnt - cnt_width_lp'(1);
    else res = cnt;
    return res;
  endfunction

  state_e                   r_state, w_state_next;
  logic                     r_prio;
  logic                     r_req_v;
  logic [pkt_width_p-1:0]   r_req_data;
  logic [id_width_p-1:0]    r_wid;
  logic [cnt_width_lp-1:0]  r_rd_cnt, r_wr_cnt;
  logic                     w_slot_free, w_ar_elig, w_aw_elig;
  logic                     w_grant_ar, w_grant_aw, w_grant_w;
  logic                     w_ar_hs, w_aw_hs, w_w_hs, w_r_last_hs, w_b_hs;
  logic [data_width_p-1:0]  w_ar_payload, w_aw_payload;
  logic [1:0]               w_rsp_type;
  logic                     w_is_r, w_is_b, w_is_rsv, w_r_bad, w_b_bad;
  logic                     w_r_valid, w_b_valid;

  assign w_slot_free = !r_req_v || bus.req_yumi_i;
  assign w_ar_elig   = bus.nasti_ar_valid_i && (r_rd_cnt < cnt_width_lp'(max_out_p));
  assign w_aw_elig   = bus.nasti_aw_valid_i && (r_wr_cnt < cnt_width_lp'(max_out_p));

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = w_aw_hs ? WDATA : IDLE;
      WDATA:   w_state_next = (w_w_hs && bus.nasti_w_last_i) ? IDLE : WDATA;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs: round-robin grant in IDLE, W channel in WDATA
  always_comb begin
    w_grant_ar = 1'b0;
    w_grant_aw = 1'b0;
    w_grant_w  = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_ar = w_ar_elig && (!w_aw_elig || !r_prio);
        w_grant_aw = w_aw_elig && (!w_ar_elig ||  r_prio);
      end
      WDATA:   w_grant_w = 1'b1;
      default: w_grant_w = 1'b0;
    endcase
  end

  assign bus.nasti_ar_ready_o = w_slot_free && w_grant_ar;
  assign bus.nasti_aw_ready_o = w_slot_free && w_grant_aw;
  assign bus.nasti_w_ready_o  = w_slot_free && w_grant_w;
  assign w_ar_hs = bus.nasti_ar_valid_i && bus.nasti_ar_ready_o;
  assign w_aw_hs = bus.nasti_aw_valid_i && bus.nasti_aw_ready_o;
  assign w_w_hs  = bus.nasti_w_valid_i  && bus.nasti_w_ready_o;

  // Zero-extend {len, addr} into the packet payload
  always_comb begin
    w_ar_payload = '0;
    w_aw_payload = '0;
    w_ar_payload[addr_width_p+7:0] = {bus.nasti_ar_len_i, bus.nasti_ar_addr_i};
    w_aw_payload[addr_width_p+7:0] = {bus.nasti_aw_len_i, bus.nasti_aw_addr_i};
  end

  // Request packet register; W packets reuse the id of the burst's AW
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_req_v    <= 1'b0;
      r_req_data <= '0;
      r_wid      <= '0;
    end else if (w_ar_hs) begin
      r_req_v    <= 1'b1;
      r_req_data <= {2'b00, 2'b00, bus.nasti_ar_id_i, w_ar_payload};
    end else if (w_aw_hs) begin
      r_req_v    <= 1'b1;
      r_req_data <= {2'b01, 2'b00, bus.nasti_aw_id_i, w_aw_payload};
      r_wid      <= bus.nasti_aw_id_i;
    end else if (w_w_hs) begin
      r_req_v    <= 1'b1;
      r_req_data <= {1'b1, bus.nasti_w_last_i, 2'b00, r_wid, bus.nasti_w_data_i};
    end else if (bus.req_yumi_i) begin
      r_req_v    <= 1'b0;
    end
  end

  assign bus.req_v_o    = r_req_v;
  assign bus.req_data_o = r_req_data;

  // Arbitration priority and outstanding-transaction counters
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_prio   <= 1'b0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_ar_hs || w_aw_hs) r_prio <= ~r_prio;
      r_rd_cnt <= f_cnt_next(r_rd_cnt, w_ar_hs, w_r_last_hs);
      r_wr_cnt <= f_cnt_next(r_wr_cnt, w_aw_hs, w_b_hs);
    end
  end

  assign w_rsp_type = bus.resp_data_i[pkt_width_p-1 -: 2];
  assign w_is_r     = bus.resp_v_i && !w_rsp_type[1];
  assign w_is_b     = bus.resp_v_i && (w_rsp_type == 2'b10);
  assign w_is_rsv   = bus.resp_v_i && (w_rsp_type == 2'b11);

`ifdef BSG_NASTI_SLAVE_RESP_CHECK_EN
  logic r_error;
  assign w_r_bad = w_is_r && (r_rd_cnt == '0);
  assign w_b_bad = w_is_b && (r_wr_cnt == '0);

  // Sticky protocol error on unexpected or reserved responses
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_error <= 1'b0;
    else            r_error <= r_error | w_r_bad | w_b_bad | w_is_rsv;
  end
  assign error_o = r_error;
`else
  assign w_r_bad = 1'b0;
  assign w_b_bad = 1'b0;
  assign error_o = 1'b0;
`endif

  assign w_r_valid   = w_is_r && !w_r_bad;
  assign w_b_valid   = w_is_b && !w_b_bad;
  assign w_r_last_hs = w_r_valid && bus.nasti_r_ready_i && w_rsp_type[0];
  assign w_b_hs      = w_b_valid && bus.nasti_b_ready_i;

  assign bus.nasti_r_valid_o = w_r_valid;
  assign bus.nasti_r_last_o  = (w_rsp_type == 2'b01);
  assign bus.nasti_r_data_o  = bus.resp_data_i[data_width_p-1:0];
  assign bus.nasti_r_id_o    = bus.resp_data_i[data_width_p +: id_width_p];
  assign bus.nasti_r_resp_o  = bus.resp_data_i[data_width_p+id_width_p +: 2];
  assign bus.nasti_b_valid_o = w_b_valid;
  assign bus.nasti_b_id_o    = bus.resp_data_i[data_width_p +: id_width_p];
  assign bus.nasti_b_resp_o  = bus.resp_data_i[data_width_p+id_width_p +: 2];
  assign bus.resp_yumi_o     = (w_is_r && (bus.nasti_r_ready_i || w_r_bad))
                             || (w_is_b && (bus.nasti_b_ready_i || w_b_bad))
                             || w_is_rsv;
endmodule

// File: tb/tb_bsg_nasti_slave.sv
// Directed, table-driven bench for bsg_nasti_slave (default parameters).
module tb_bsg_nasti_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bsg_nasti_slave_if #(.addr_width_p(32), .data_width_p(64), .id_width_p(5)) bus ();

  bsg_nasti_slave #(.addr_width_p(32), .data_width_p(64), .id_width_p(5), .max_out_p(8)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bus), .error_o(err));

  typedef struct {
    logic [31:0] addr; logic [7:0] len; logic [4:0] id; logic [63:0] e_payload;
  } ar_vec_t;

  typedef struct {
    logic v; logic [1:0] typ; logic [4:0] id; logic [1:0] resp; logic [63:0] data;
    logic r_rdy; logic b_rdy; logic e_rv; logic e_rl; logic e_bv; logic e_yumi;
  } rsp_vec_t;

  ar_vec_t  ar_tab [8];
  rsp_vec_t rsp_tab [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [72:0] pk(input logic [1:0] t, input logic [4:0] id, input logic [63:0] p);
    return {t, 2'b00, id, p};
  endfunction

  task automatic set_ar(input logic v, input logic [31:0] a, input logic [7:0] l, input logic [4:0] id);
    bus.nasti_ar_valid_i = v; bus.nasti_ar_addr_i = a; bus.nasti_ar_len_i = l; bus.nasti_ar_id_i = id;
  endtask

  task automatic set_aw(input logic v, input logic [31:0] a, input logic [7:0] l, input logic [4:0] id);
    bus.nasti_aw_valid_i = v; bus.nasti_aw_addr_i = a; bus.nasti_aw_len_i = l; bus.nasti_aw_id_i = id;
  endtask

  task automatic set_rsp(input logic v, input logic [1:0] t, input logic [4:0] id,
                         input logic [1:0] rs, input logic [63:0] d);
    bus.resp_v_i = v; bus.resp_data_i = {t, rs, id, d};
  endtask

  initial begin
    ar_tab[0] = '{32'h8000_1000, 8'd3,   5'd5,  64'h0000_0003_8000_1000};
    ar_tab[1] = '{32'h0000_0040, 8'd0,   5'd1,  64'h0000_0000_0000_0040};
    ar_tab[2] = '{32'hFFFF_FFFC, 8'd255, 5'd31, 64'h0000_00FF_FFFF_FFFC};
    ar_tab[3] = '{32'h1234_5678, 8'd7,   5'd0,  64'h0000_0007_1234_5678};
    ar_tab[4] = '{32'h0000_0000, 8'd1,   5'd2,  64'h0000_0001_0000_0000};
    ar_tab[5] = '{32'hA5A5_5A5A, 8'd128, 5'd16, 64'h0000_0080_A5A5_5A5A};
    ar_tab[6] = '{32'h0000_1000, 8'd15,  5'd3,  64'h0000_000F_0000_1000};
    ar_tab[7] = '{32'h7FFF_FFFF, 8'd2,   5'd30, 64'h0000_0002_7FFF_FFFF};
    rsp_tab[0] = '{1'b0, 2'b00, 5'd5, 2'b00, 64'h0,                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rsp_tab[1] = '{1'b1, 2'b00, 5'd5, 2'b00, 64'h11,                  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rsp_tab[2] = '{1'b1, 2'b00, 5'd5, 2'b00, 64'h11,                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    rsp_tab[3] = '{1'b1, 2'b00, 5'd5, 2'b10, 64'h22,                  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rsp_tab[4] = '{1'b1, 2'b01, 5'd5, 2'b00, 64'h33,                  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rsp_tab[5] = '{1'b1, 2'b01, 5'd6, 2'b11, 64'hFFFF_0000_1234_5678, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    set_ar(1'b0, 32'h0, 8'd0, 5'd0);
    set_aw(1'b0, 32'h0, 8'd0, 5'd0);
    bus.nasti_w_valid_i = 1'b0; bus.nasti_w_data_i = 64'h0; bus.nasti_w_last_i = 1'b0;
    bus.nasti_r_ready_i = 1'b0; bus.nasti_b_ready_i = 1'b0;
    bus.req_yumi_i = 1'b1;
    set_rsp(1'b0, 2'b00, 5'd0, 2'b00, 64'h0);

    // Reset state
    #12;
    chk("rst_req_v", bus.req_v_o, 1'b0);
    chk("rst_req_data", bus.req_data_o, 73'h0);
    chk("rst_error", err, 1'b0);
    chk("rst_ar_ready_idle", bus.nasti_ar_ready_o, 1'b0);
    chk("rst_w_ready", bus.nasti_w_ready_o, 1'b0);
    bus.nasti_ar_valid_i = 1'b1;
    #1 chk("rst_ar_ready_pending", bus.nasti_ar_ready_o, 1'b1);
    bus.nasti_ar_valid_i = 1'b0;
    step(); rst_n = 1'b1; step();

    // Table: eight reads up to the outstanding limit
    for (int i = 0; i < 8; i++) begin
      set_ar(1'b1, ar_tab[i].addr, ar_tab[i].len, ar_tab[i].id);
      #1 chk($sformatf("ar_ready[%0d]", i), bus.nasti_ar_ready_o, 1'b1);
      step();
      bus.nasti_ar_valid_i = 1'b0;
      chk($sformatf("ar_req_v[%0d]", i), bus.req_v_o, 1'b1);
      chk($sformatf("ar_pkt[%0d]", i), bus.req_data_o, pk(2'b00, ar_tab[i].id, ar_tab[i].e_payload));
    end
    set_ar(1'b1, 32'h0000_0100, 8'd0, 5'd9);
    #1 chk("ar9_blocked_a", bus.nasti_ar_ready_o, 1'b0);
    step();
    chk("ar9_blocked_b", bus.nasti_ar_ready_o, 1'b0);
    chk("req_v_drained", bus.req_v_o, 1'b0);
    bus.nasti_ar_valid_i = 1'b0;

    // Table: response pass-through
    for (int i = 0; i < 6; i++) begin
      set_rsp(rsp_tab[i].v, rsp_tab[i].typ, rsp_tab[i].id, rsp_tab[i].resp, rsp_tab[i].data);
      bus.nasti_r_ready_i = rsp_tab[i].r_rdy; bus.nasti_b_ready_i = rsp_tab[i].b_rdy;
      #1;
      chk($sformatf("rsp_rv[%0d]", i), bus.nasti_r_valid_o, rsp_tab[i].e_rv);
      chk($sformatf("rsp_rl[%0d]", i), bus.nasti_r_last_o, rsp_tab[i].e_rl);
      chk($sformatf("rsp_bv[%0d]", i), bus.nasti_b_valid_o, rsp_tab[i].e_bv);
      chk($sformatf("rsp_yumi[%0d]", i), bus.resp_yumi_o, rsp_tab[i].e_yumi);
      chk($sformatf("rsp_data[%0d]", i), bus.nasti_r_data_o, rsp_tab[i].data);
      chk($sformatf("rsp_id[%0d]", i), bus.nasti_r_id_o, rsp_tab[i].id);
      chk($sformatf("rsp_resp[%0d]", i), bus.nasti_r_resp_o, rsp_tab[i].resp);
      step();
    end
    bus.resp_v_i = 1'b0;

    // One R-last completed: the ninth read is now accepted
    set_ar(1'b1, 32'h0000_0100, 8'd0, 5'd9);
    #1 chk("ar9_ready", bus.nasti_ar_ready_o, 1'b1);
    step();
    bus.nasti_ar_valid_i = 1'b0;
    chk("ar9_pkt", bus.req_data_o, pk(2'b00, 5'd9, 64'h0000_0000_0000_0100));
    for (int i = 0; i < 8; i++) begin
      set_rsp(1'b1, 2'b01, 5'd0, 2'b00, 64'(i));
      bus.nasti_r_ready_i = 1'b1;
      #1 chk($sformatf("drain_yumi[%0d]", i), bus.resp_yumi_o, 1'b1);
      step();
    end
    bus.resp_v_i = 1'b0;

    // Write burst with a competing read held valid (priority now favours AW)
    set_aw(1'b1, 32'h0000_2000, 8'd1, 5'd2);
    set_ar(1'b1, 32'h0000_3000, 8'd0, 5'd4);
    #1 chk("wb_aw_ready", bus.nasti_aw_ready_o, 1'b1);
    chk("wb_ar_wait0", bus.nasti_ar_ready_o, 1'b0);
    step();
    bus.nasti_aw_valid_i = 1'b0;
    chk("wb_aw_pkt", bus.req_data_o, pk(2'b01, 5'd2, 64'h0000_0001_0000_2000));
    bus.nasti_w_valid_i = 1'b1; bus.nasti_w_data_i = 64'hA; bus.nasti_w_last_i = 1'b0;
    #1 chk("wb_w0_ready", bus.nasti_w_ready_o, 1'b1);
    chk("wb_ar_wait1", bus.nasti_ar_ready_o, 1'b0);
    step();
    chk("wb_w0_pkt", bus.req_data_o, pk(2'b10, 5'd2, 64'hA));
    bus.nasti_w_data_i = 64'hB; bus.nasti_w_last_i = 1'b1;
    #1 chk("wb_w1_ready", bus.nasti_w_ready_o, 1'b1);
    chk("wb_ar_wait2", bus.nasti_ar_ready_o, 1'b0);
    step();
    bus.nasti_w_valid_i = 1'b0; bus.nasti_w_last_i = 1'b0;
    chk("wb_wlast_pkt", bus.req_data_o, pk(2'b11, 5'd2, 64'hB));
    #1 chk("wb_ar_after", bus.nasti_ar_ready_o, 1'b1);
    chk("wb_w_ready_idle", bus.nasti_w_ready_o, 1'b0);
    step();
    bus.nasti_ar_valid_i = 1'b0;
    chk("wb_ar_pkt", bus.req_data_o, pk(2'b00, 5'd4, 64'h0000_0000_0000_3000));
    set_rsp(1'b1, 2'b10, 5'd2, 2'b00, 64'h0);
    bus.nasti_b_ready_i = 1'b1;
    #1 chk("b_valid", bus.nasti_b_valid_o, 1'b1);
    chk("b_id", bus.nasti_b_id_o, 5'd2);
    chk("b_resp", bus.nasti_b_resp_o, 2'b00);
    chk("b_r_valid", bus.nasti_r_valid_o, 1'b0);
    chk("b_yumi", bus.resp_yumi_o, 1'b1);
    step();
    set_rsp(1'b1, 2'b01, 5'd4, 2'b00, 64'hDEAD);
    #1 chk("r4_last", bus.nasti_r_last_o, 1'b1);
    chk("r4_id", bus.nasti_r_id_o, 5'd4);
    step();
    bus.resp_v_i = 1'b0;

    // Backpressure: the held packet stays put and no channel is ready
    bus.req_yumi_i = 1'b0;
    set_ar(1'b1, 32'h0000_4000, 8'd1, 5'd6);
    #1 chk("bp_ar_ready", bus.nasti_ar_ready_o, 1'b1);
    step();
    set_ar(1'b1, 32'h0000_5000, 8'd0, 5'd7);
    set_aw(1'b1, 32'h0000_5100, 8'd0, 5'd7);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("bp_v[%0d]", i), bus.req_v_o, 1'b1);
      chk($sformatf("bp_data[%0d]", i), bus.req_data_o, pk(2'b00, 5'd6, 64'h0000_0001_0000_4000));
      chk($sformatf("bp_ar_rdy[%0d]", i), bus.nasti_ar_ready_o, 1'b0);
      chk($sformatf("bp_aw_rdy[%0d]", i), bus.nasti_aw_ready_o, 1'b0);
      step();
    end
    bus.nasti_ar_valid_i = 1'b0; bus.nasti_aw_valid_i = 1'b0;
    bus.req_yumi_i = 1'b1;
    step();
    chk("bp_release", bus.req_v_o, 1'b0);

    // Reset asserted in the middle of a write burst
    set_aw(1'b1, 32'h0000_6000, 8'd3, 5'd7);
    #1 chk("mr_aw_ready", bus.nasti_aw_ready_o, 1'b1);
    step();
    bus.nasti_aw_valid_i = 1'b0;
    bus.nasti_w_valid_i = 1'b1; bus.nasti_w_data_i = 64'h1; bus.nasti_w_last_i = 1'b0;
    #1 chk("mr_w_ready", bus.nasti_w_ready_o, 1'b1);
    step();
    rst_n = 1'b0;
    bus.nasti_aw_valid_i = 1'b1;
    #1 chk("mr_req_v", bus.req_v_o, 1'b0);
    chk("mr_req_data", bus.req_data_o, 73'h0);
    chk("mr_w_ready_off", bus.nasti_w_ready_o, 1'b0);
    chk("mr_aw_ready_idle", bus.nasti_aw_ready_o, 1'b1);
    bus.nasti_aw_valid_i = 1'b0; bus.nasti_w_valid_i = 1'b0;
    step(); rst_n = 1'b1; step();

    // Arbitration after reset: AR, then AW, then AR again
    set_ar(1'b1, 32'h0000_7000, 8'd0, 5'd8);
    set_aw(1'b1, 32'h0000_8000, 8'd0, 5'd9);
    #1 chk("arb1_ar", bus.nasti_ar_ready_o, 1'b1);
    chk("arb1_aw", bus.nasti_aw_ready_o, 1'b0);
    step();
    chk("arb1_pkt", bus.req_data_o, pk(2'b00, 5'd8, 64'h0000_0000_0000_7000));
    set_ar(1'b1, 32'h0000_7100, 8'd0, 5'd10);
    #1 chk("arb2_aw", bus.nasti_aw_ready_o, 1'b1);
    chk("arb2_ar", bus.nasti_ar_ready_o, 1'b0);
    step();
    bus.nasti_aw_valid_i = 1'b0;
    chk("arb2_pkt", bus.req_data_o, pk(2'b01, 5'd9, 64'h0000_0000_0000_8000));
    bus.nasti_w_valid_i = 1'b1; bus.nasti_w_data_i = 64'hC; bus.nasti_w_last_i = 1'b1;
    #1 chk("arb_w_ready", bus.nasti_w_ready_o, 1'b1);
    chk("arb_ar_blocked", bus.nasti_ar_ready_o, 1'b0);
    step();
    bus.nasti_w_valid_i = 1'b0; bus.nasti_w_last_i = 1'b0;
    chk("arb_wlast_pkt", bus.req_data_o, pk(2'b11, 5'd9, 64'hC));
    set_aw(1'b1, 32'h0000_9000, 8'd0, 5'd11);
    #1 chk("arb3_ar", bus.nasti_ar_ready_o, 1'b1);
    chk("arb3_aw", bus.nasti_aw_ready_o, 1'b0);
    step();
    bus.nasti_ar_valid_i = 1'b0; bus.nasti_aw_valid_i = 1'b0;
    chk("arb3_pkt", bus.req_data_o, pk(2'b00, 5'd10, 64'h0000_0000_0000_7100));

    // Expected B brings the write count to zero, then an unexpected B
    set_rsp(1'b1, 2'b10, 5'd9, 2'b00, 64'h0);
    bus.nasti_b_ready_i = 1'b1;
    #1 chk("b9_valid", bus.nasti_b_valid_o, 1'b1);
    step();
    set_rsp(1'b1, 2'b10, 5'd9, 2'b01, 64'h0);
    #1 chk("bx_yumi", bus.resp_yumi_o, 1'b1);
`ifdef BSG_NASTI_SLAVE_RESP_CHECK_EN
    chk("bx_valid_dropped", bus.nasti_b_valid_o, 1'b0);
    chk("bx_err_before", err, 1'b0);
    step();
    bus.resp_v_i = 1'b0;
    chk("bx_err_set", err, 1'b1);
    step();
    chk("bx_err_sticky", err, 1'b1);
`else
    chk("bx_valid_fwd", bus.nasti_b_valid_o, 1'b1);
    chk("bx_resp_fwd", bus.nasti_b_resp_o, 2'b01);
    step();
    bus.resp_v_i = 1'b0;
    chk("bx_err_clear", err, 1'b0);
    step();
    chk("bx_err_clear2", err, 1'b0);
`endif

    // Reserved response type is always consumed without a NASTI valid
    set_rsp(1'b1, 2'b11, 5'd3, 2'b00, 64'h5);
    bus.nasti_r_ready_i = 1'b0; bus.nasti_b_ready_i = 1'b0;
    #1 chk("rsv_yumi", bus.resp_yumi_o, 1'b1);
    chk("rsv_rv", bus.nasti_r_valid_o, 1'b0);
    chk("rsv_bv", bus.nasti_b_valid_o, 1'b0);
    step();
    bus.resp_v_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
